// File: rtl/enc_r2_modred_if.sv
// rtl/enc_r2_modred_if.sv - start/busy/done request bundle for the modular-reduction encrypt stage (err port under ENC_R2_ZCHK_EN)
interface enc_r2_modred_if #(
    parameter int EXP_W = 64,
    parameter int P_W   = 32,
    parameter int KEY_W = 4
);
    logic             start;
    logic [EXP_W-1:0] exp;
    logic [P_W-1:0]   p;
    logic [KEY_W-1:0] msg;
    logic             busy;
    logic             done;
    logic [KEY_W-1:0] k_o;
    logic [KEY_W-1:0] c1;
`ifdef ENC_R2_ZCHK_EN
    logic             err;

    modport master (output start, exp, p, msg, input busy, done, k_o, c1, err);
    modport slave  (input start, exp, p, msg, output busy, done, k_o, c1, err);
`else
    modport master (output start, exp, p, msg, input busy, done, k_o, c1);
    modport slave  (input start, exp, p, msg, output busy, done, k_o, c1);
`endif
endinterface

// File: rtl/enc_r2_modred.sv
// rtl/enc_r2_modred.sv - bit-serial restoring exp mod p reducer, key/ciphertext stage (optional p==0 check: ENC_R2_ZCHK_EN)
module enc_r2_modred #(
    parameter int EXP_W = 64,
    parameter int P_W   = 32,
    parameter int KEY_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    enc_r2_modred_if.slave     bus
);
    localparam int CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXP_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [EXP_W-1:0] exp_sh;
    logic [P_W-1:0]   p_q;
    logic [KEY_W-1:0] msg_q;
    logic [P_W:0]     rem_q;
    logic [P_W:0]     rem_next;
    logic [P_W+1:0]   t;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [KEY_W-1:0] k_q;
    logic [KEY_W-1:0] c1_q;
    logic             take_sub;
`ifdef ENC_R2_ZCHK_EN
    logic             err_q;
`endif

    // One restoring step; a zero modulus disables subtraction so rem just shifts in exp.
    always_comb begin
        t        = {rem_q, exp_sh[EXP_W-1]};
        take_sub = (p_q != '0) && (t >= {2'b00, p_q});
        rem_next = t[P_W:0];
        if (take_sub) begin
            rem_next = t[P_W:0] - {1'b0, p_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
`ifdef ENC_R2_ZCHK_EN
                    state_d = (bus.p == '0) ? DONE : RUN;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN:     if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            exp_sh <= '0;
            p_q    <= '0;
            msg_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            k_q    <= '0;
            c1_q   <= '0;
`ifdef ENC_R2_ZCHK_EN
            err_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            // busy stays up through the done pulse and drops on the edge that ends it
            busy_q <= (state_d != IDLE) || (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        exp_sh <= bus.exp;
                        p_q    <= bus.p;
                        msg_q  <= bus.msg;
                        rem_q  <= '0;
                        cnt_q  <= CNT_LAST;
`ifdef ENC_R2_ZCHK_EN
                        err_q  <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    rem_q  <= rem_next;
                    exp_sh <= exp_sh << 1;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
`ifdef ENC_R2_ZCHK_EN
                    if (p_q == '0) begin
                        k_q   <= '0;
                        c1_q  <= '0;
                        err_q <= 1'b1;
                    end else begin
                        k_q   <= rem_q[KEY_W-1:0];
                        c1_q  <= rem_q[KEY_W-1:0] ^ msg_q;
                        err_q <= 1'b0;
                    end
`else
                    k_q  <= rem_q[KEY_W-1:0];
                    c1_q <= rem_q[KEY_W-1:0] ^ msg_q;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.k_o  = k_q;
    assign bus.c1   = c1_q;
`ifdef ENC_R2_ZCHK_EN
    assign bus.err  = err_q;
`endif
endmodule
